// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length codec and its word packer.
package rle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_PROC,
    ST_WR,
    ST_DONE
  } rle_state_e;

  typedef enum logic {
    RLE_COMPRESS   = 1'b0,
    RLE_DECOMPRESS = 1'b1
  } rle_mode_e;

  localparam int unsigned SYM_MSB    = 15;
  localparam int unsigned SYM_LSB    = 8;
  localparam int unsigned CNT_MSB    = 7;
  localparam int unsigned CNT_LSB    = 0;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/rle_word_packer.sv
// 32-bit output accumulator: packs 8-bit or 16-bit lanes low-first, zero-filled
// until flushed.
module rle_word_packer
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        wide,
  input  logic        push,
  input  logic        flush,
  input  logic [15:0] push_data,
  output logic [31:0] word,
  output logic [2:0]  byte_cnt,
  output logic        full,
  output logic        fill_last
);

  logic [2:0]  lane;
  logic [31:0] lane_data;

  assign lane      = wide ? 3'd2 : 3'd1;
  assign lane_data = wide ? {16'h0000, push_data} : {24'h000000, push_data[7:0]};
  assign full      = (byte_cnt == 3'(WORD_BYTES));
  assign fill_last = (byte_cnt + lane == 3'(WORD_BYTES));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (flush) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (push && !full) begin
      word     <= word | (lane_data << {byte_cnt[1:0], 3'b000});
      byte_cnt <= byte_cnt + lane;
    end
  end

endmodule

// File: rtl/rle_codec.sv
// Run-length codec over a single-port 32-bit SRAM: compresses bytes into
// {symbol,count} pairs or expands pairs back into bytes, one frame per start.
module rle_codec
  import rle_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MAX_RUN = 255
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              mode,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [31:0]       src_size,
  output logic [31:0]       dst_size,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic              port_A_clk
);

  localparam logic [7:0] MAX_RUN_B = 8'(MAX_RUN);

  rle_state_e        state, next_state;
  rle_mode_e         mode_r;
  logic [31:0]       size_r, in_cnt, dst_cnt, in_word, shifted;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [1:0]        in_idx;
  logic              word_valid, run_valid;
  logic [7:0]        run_sym, run_cnt, cur_sym, rem, cur_byte;
  logic [15:0]       cur_pair, push_data;
  logic [2:0]        step, pk_cnt;
  logic [31:0]       pk_word;
  logic              accept, in_done, word_last, push, consume, pk_full, pk_fill_last;
  logic              addr_unused;

  assign port_A_clk  = clk;
  assign addr_unused = ^{src_addr, dst_addr, shifted[31:16]};
  assign accept      = start && (state == ST_IDLE || state == ST_DONE);
  assign step        = (mode_r == RLE_DECOMPRESS) ? 3'd2 : 3'd1;
  assign shifted     = in_word >> {in_idx, 3'b000};
  assign cur_byte    = shifted[7:0];
  assign cur_pair    = shifted[15:0];
  assign in_done     = (in_cnt >= size_r);
  assign word_last   = ({1'b0, in_idx} + step == 3'(WORD_BYTES)) || (in_cnt + 32'(step) >= size_r);
  assign dst_size    = dst_cnt;

  rle_word_packer u_packer (
    .clk       (clk),
    .nreset    (nreset),
    .wide      (mode_r == RLE_COMPRESS),
    .push      (push),
    .flush     (accept || state == ST_WR),
    .push_data (push_data),
    .word      (pk_word),
    .byte_cnt  (pk_cnt),
    .full      (pk_full),
    .fill_last (pk_fill_last)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: if (accept) next_state = (src_size == '0) ? ST_PROC : ST_RD_REQ;
      ST_RD_REQ:  next_state = ST_RD_WAIT;
      ST_RD_WAIT: next_state = ST_PROC;
      ST_PROC: begin
        if ((push && pk_fill_last) || pk_full)        next_state = ST_WR;
        else if (rem != '0 || word_valid)             next_state = ST_PROC;
        else if (!in_done)                            next_state = ST_RD_REQ;
        else if (push || run_valid || pk_cnt != '0)   next_state = ST_WR;
        else                                          next_state = ST_DONE;
      end
      ST_WR: next_state = (in_done && !word_valid && !run_valid && rem == '0) ? ST_DONE : ST_PROC;
      default: next_state = ST_IDLE;
    endcase
  end

  // In compress, a byte that breaks the run (or hits MAX_RUN) pushes the old pair
  // in the same cycle it is consumed; the final pair is pushed once input runs dry.
  always_comb begin
    push           = 1'b0;
    consume        = 1'b0;
    push_data      = '0;
    port_A_addr    = '0;
    port_A_we      = 1'b0;
    port_A_data_in = '0;
    busy           = (state != ST_IDLE) && (state != ST_DONE);
    done           = (state == ST_DONE);
    case (state)
      ST_RD_REQ: port_A_addr = rd_addr;
      ST_WR: begin
        port_A_addr    = wr_addr;
        port_A_we      = 1'b1;
        port_A_data_in = pk_word;
      end
      ST_PROC: begin
        if (mode_r == RLE_COMPRESS) begin
          push_data[SYM_MSB:SYM_LSB] = run_sym;
          push_data[CNT_MSB:CNT_LSB] = run_cnt;
          if (word_valid) begin
            consume = 1'b1;
            push    = run_valid && !(cur_byte == run_sym && run_cnt < MAX_RUN_B);
          end else begin
            push = in_done && run_valid;
          end
        end else begin
          push_data[7:0] = cur_sym;
          if (rem != '0) push = 1'b1;
          else           consume = word_valid;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mode_r     <= RLE_COMPRESS;
      size_r     <= '0;
      in_cnt     <= '0;
      dst_cnt    <= '0;
      in_word    <= '0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      in_idx     <= '0;
      word_valid <= 1'b0;
      run_valid  <= 1'b0;
      run_sym    <= '0;
      run_cnt    <= '0;
      cur_sym    <= '0;
      rem        <= '0;
    end else if (accept) begin
      mode_r     <= rle_mode_e'(mode);
      size_r     <= src_size;
      rd_addr    <= {src_addr[ADDR_W-1:2], 2'b00};
      wr_addr    <= {dst_addr[ADDR_W-1:2], 2'b00};
      in_cnt     <= '0;
      dst_cnt    <= '0;
      in_idx     <= '0;
      word_valid <= 1'b0;
      run_valid  <= 1'b0;
      rem        <= '0;
    end else begin
      case (state)
        ST_RD_WAIT: begin
          in_word    <= port_A_data_out;
          in_idx     <= '0;
          word_valid <= 1'b1;
          rd_addr    <= rd_addr + ADDR_W'(4);
        end
        ST_WR: begin
          wr_addr <= wr_addr + ADDR_W'(4);
          dst_cnt <= dst_cnt + 32'(pk_cnt);
        end
        ST_PROC: begin
          if (consume) begin
            in_cnt <= in_cnt + 32'(step);
            in_idx <= in_idx + step[1:0];
            if (word_last) word_valid <= 1'b0;
          end
          if (mode_r == RLE_COMPRESS) begin
            if (consume) begin
              if (push || !run_valid) begin
                run_sym   <= cur_byte;
                run_cnt   <= 8'd1;
                run_valid <= 1'b1;
              end else begin
                run_cnt <= run_cnt + 8'd1;
              end
            end else if (push) begin
              run_valid <= 1'b0;
            end
          end else begin
            if (push) begin
              rem <= rem - 8'd1;
            end else if (consume) begin
              cur_sym <= cur_pair[SYM_MSB:SYM_LSB];
              rem     <= cur_pair[CNT_MSB:CNT_LSB];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_codec.sv
// Directed bench for rle_codec: SRAM model, vector table, plus split-run,
// mid-frame reset and start-while-busy sequences.
module tb_rle_codec;

  logic        clk, nreset, start, mode;
  logic [31:0] src_addr, dst_addr, src_size, dst_size;
  logic        busy, done;
  logic [15:0] port_A_addr;
  logic        port_A_we, port_A_clk;
  logic [31:0] port_A_data_in, port_A_data_out;

  rle_codec #(.ADDR_W(16), .MAX_RUN(255)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .start           (start),
    .mode            (mode),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .src_size        (src_size),
    .dst_size        (dst_size),
    .busy            (busy),
    .done            (done),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out),
    .port_A_clk      (port_A_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with a bench-side load port used only while the DUT is idle
  logic [31:0] mem [0:16383];
  logic        ld_we;
  logic [13:0] ld_idx;
  logic [31:0] ld_data;
  int          wr_count = 0;
  int          both_high = 0;

  always @(posedge clk) begin
    if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
    else if (ld_we) mem[ld_idx] <= ld_data;
    if (!port_A_we) port_A_data_out <= mem[port_A_addr[15:2]];
  end
  always @(posedge clk) if (port_A_we) wr_count <= wr_count + 1;
  always @(negedge clk) if (busy && done) both_high <= both_high + 1;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;
  localparam int NV = 10;

  typedef struct {
    logic        mode;
    int unsigned size;
    logic [127:0] src;
    logic [127:0] exp;
    int unsigned exp_size;
  } vec_t;

  vec_t vecs [NV];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    ld_we = 1'b1; ld_idx = 14'(idx); ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic start_frame(input logic m, input int unsigned sz, input logic [31:0] sa, input logic [31:0] da);
    @(negedge clk);
    mode = m; src_size = sz; src_addr = sa; dst_addr = da; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 1;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int cyc, nw, bound, w0, wd;
    string nm;
    logic we_seen;

    vecs[0] = '{1'b0, 8, {64'h0, 32'hCCCC_CCCC, 32'hBBAA_AAAA}, {64'h0, 32'h0000_CC04, 32'hBB01_AA03}, 6};
    vecs[1] = '{1'b1, 6, {64'h0, 32'h0000_CC04, 32'hBB01_AA03}, {64'h0, 32'hCCCC_CCCC, 32'hBBAA_AAAA}, 8};
    vecs[2] = '{1'b1, 8, {64'h0, 32'hCC04_BB01, 32'h0000_AA03}, {64'h0, 32'hCCCC_CCCC, 32'hBBAA_AAAA}, 8};
    vecs[3] = '{1'b0, 5, {64'h0, 32'h7777_7733, 32'h3322_2211}, {64'h0, 32'h0000_3302, 32'h2202_1101}, 6};
    vecs[4] = '{1'b1, 2, {96'h0, 32'hFFFF_4105}, {64'h0, 32'h0000_0041, 32'h4141_4141}, 5};
    vecs[5] = '{1'b0, 0, {96'h0, 32'h1234_5678}, 128'h0, 0};
    vecs[6] = '{1'b1, 0, {96'h0, 32'h1234_5678}, 128'h0, 0};
    vecs[7] = '{1'b0, 4, {96'h0, 32'h0403_0201}, {64'h0, 32'h0401_0301, 32'h0201_0101}, 8};
    vecs[8] = '{1'b0, 6, {64'h0, 32'h5A5A_9999, 32'h9999_9999}, {96'h0, 32'h0000_9906}, 2};
    vecs[9] = '{1'b1, 4, {96'h0, 32'h7F01_8002}, {96'h0, 32'h007F_8080}, 3};

    nreset = 1'b0; start = 1'b0; mode = 1'b0; ld_we = 1'b0; ld_idx = '0; ld_data = '0;
    src_addr = '0; dst_addr = '0; src_size = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dst_size", dst_size, 32'd0);
    check("reset we", 32'(port_A_we), 32'd0);
    check("reset addr", 32'(port_A_addr), 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < 4; k++) poke(16'h0040 + k, vecs[i].src[32*k +: 32]);
      for (int k = 0; k < 4; k++) poke(16'h0100 + k, SENT);
      nw = int'((vecs[i].exp_size + 3) / 4);
      bound = (vecs[i].size == 0) ? 3 :
              int'(vecs[i].size + vecs[i].exp_size + 2 * ((vecs[i].size + 3) / 4)) + nw + 4;
      w0 = wr_count;
      nm = $sformatf("vec%0d", i);
      start_frame(vecs[i].mode, vecs[i].size, 32'h0000_0100, 32'h0000_0400);
      wait_done(nm, cyc);
      check({nm, " dst_size"}, dst_size, vecs[i].exp_size);
      for (int k = 0; k < nw; k++)
        check($sformatf("%s word%0d", nm, k), mem[16'h0100 + k], vecs[i].exp[32*k +: 32]);
      check({nm, " untouched"}, mem[16'h0100 + nw], SENT);
      check({nm, " writes"}, 32'(wr_count - w0), 32'(nw));
      checks++;
      if (cyc > bound) begin
        errors++;
        $display("FAIL %s cycles: got %0d expected <= %0d", nm, cyc, bound);
      end
    end

    // 300 bytes of 0x55 split at MAX_RUN into 0x55FF and 0x552D
    for (int k = 0; k < 75; k++) poke(16'h0400 + k, 32'h5555_5555);
    for (int k = 0; k < 2; k++) poke(16'h0800 + k, SENT);
    w0 = wr_count;
    start_frame(1'b0, 300, 32'h0000_1000, 32'h0000_2000);
    wait_done("split", cyc);
    check("split word0", mem[16'h0800], 32'h552D_55FF);
    check("split untouched", mem[16'h0801], SENT);
    check("split dst_size", dst_size, 32'd4);
    check("split writes", 32'(wr_count - w0), 32'd1);

    // mid-frame reset: outputs clear at once and no writes follow
    start_frame(1'b0, 300, 32'h0000_1000, 32'h0000_2000);
    repeat (100) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    wd = wr_count;
    nreset = 1'b0;
    #1;
    check("async busy", 32'(busy), 32'd0);
    check("async done", 32'(done), 32'd0);
    check("async dst_size", dst_size, 32'd0);
    we_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      we_seen = we_seen | port_A_we;
    end
    check("reset we low", 32'(we_seen), 32'd0);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    check("post-reset writes", 32'(wr_count - wd), 32'd0);
    check("post-reset done", 32'(done), 32'd0);

    // fresh frame after reset, with a start and input changes while busy
    for (int k = 0; k < 2; k++) poke(16'h0040 + k, vecs[0].src[32*k +: 32]);
    for (int k = 0; k < 4; k++) poke(16'h0100 + k, SENT);
    for (int k = 0; k < 4; k++) poke(16'h0200 + k, SENT);
    start_frame(1'b0, 8, 32'h0000_0100, 32'h0000_0400);
    repeat (3) @(negedge clk);
    check("busy before restart", 32'(busy), 32'd1);
    mode = 1'b1; src_size = 32'd0; dst_addr = 32'h0000_0800; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart", cyc);
    check("restart word0", mem[16'h0100], 32'hBB01_AA03);
    check("restart word1", mem[16'h0101], 32'h0000_CC04);
    check("restart dst_size", dst_size, 32'd6);
    check("restart other dst", mem[16'h0200], SENT);
    check("busy with done", 32'(both_high), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_codec.md
# rle_codec

Parametrised run-length codec: successor to the team's byte RLE compressor, adding a decompress mode, bounded run splitting and exact output sizing. It owns a single-port 32-bit SRAM port and processes one frame per `start`. The frame is read from `src_addr`, and the result is written to `dst_addr`. It sits beside the existing compressor on the same dpsram and is controlled by the same host sequencer.

## Interface
- `ADDR_W`, default 16: SRAM byte-address width. Addresses are word aligned; bits [1:0] are ignored.
- `MAX_RUN`, default 255: longest run emitted in one pair, legal range 1..255. Longer runs are split.
- `clk` in, 1 bit: clock. `port_A_clk` is driven directly from `clk`.
- `nreset` in, 1 bit: reset, asynchronous, active-low.
- `start` in, 1 bit: one-cycle pulse. Sampled only in IDLE or DONE.
- `mode` in, 1 bit: 0 = compress, 1 = decompress. Sampled with `start`.
- `src_addr`, `dst_addr` in, 32 bits: frame base addresses. The low `ADDR_W` bits are used.
- `src_size` in, 32 bits: input length in bytes. In decompress mode it must be a multiple of 2.
- `dst_size` out, 32 bits: meaningful output bytes. Reset value 0.
- `busy` out, 1 bit: high from the cycle after an accepted `start` until DONE. Reset value 0.
- `done` out, 1 bit: level, high in DONE until the next accepted `start`. Reset value 0.
- `port_A_addr` out, `ADDR_W` bits: reset value 0.
- `port_A_we` out, 1 bit: reset value 0.
- `port_A_data_in` out, 32 bits: reset value 0.
- `port_A_data_out` in, 32 bits: read data, valid the cycle after the address is presented with `we`=0.
- `port_A_clk` out, 1 bit.

## Operation
- Byte order is little-endian: stream byte k of a word is bits [8k+7:8k].
- A pair is 16 bits: symbol in [15:8], run length in [7:0], range 1..MAX_RUN.
- Pairs are packed two per word, low half first.
- Compress:
  - Emit one pair per maximal run.
  - When a run reaches MAX_RUN, emit the pair and start a new run of the same symbol.
  - `dst_size` = 2 × pairs.
  - An odd final pair is written with upper half 0.
- Decompress:
  - Read pairs in order and emit `count` copies of `symbol`, packed four per word.
  - A pair with count 0 is padding: skip it and emit no bytes.
  - `dst_size` = total bytes emitted.
  - A partial final word is zero-filled in the unused bytes.
- States and transitions:
  - IDLE → RD_REQ on `start`.
  - RD_REQ → RD_WAIT.
  - RD_WAIT → PROC.
  - PROC → WR when the output word is full or at a final flush.
  - PROC → RD_REQ when the input word is exhausted.
  - PROC → DONE when the input is exhausted and nothing is pending.
  - WR → PROC, or WR → DONE after the final flush.
  - DONE → RD_REQ on `start`.
- Source bytes beyond `src_size` in the last word are ignored.
- Arithmetic widths:
  - Input/output byte counters are 32 bits.
  - Run counter is 8 bits and never exceeds MAX_RUN.
  - Addresses increment by 4 and wrap modulo 2^ADDR_W with no error.
- `src_size` = 0: no reads, no writes, `dst_size` = 0, DONE reached within 3 cycles of `start`.
- `start` while `busy` is ignored.
- `mode` and `src_size` changes while busy have no effect.
- `nreset` mid-frame: all outputs return to reset values immediately and no further writes occur. Memory already written is left as is.

## Timing
- At most one SRAM access per cycle; a read and a write never share a cycle.
- Compress processes one input byte per PROC cycle.
- Decompress emits one output byte per PROC cycle.
- Each word read costs 2 extra cycles (RD_REQ, RD_WAIT). Each word write costs 1 cycle (WR).
- Bound on total cycles from `start` to `done`: input bytes + output bytes + 2 × words read + words written + 4.
- `dst_size` is stable and final in the first cycle `done` is high.
- `done` and `busy` are never high together.

## Structure
- Package `rle_pkg` holds:
  - the state enum;
  - the mode encoding (`RLE_COMPRESS`, `RLE_DECOMPRESS`);
  - pair field positions (`SYM_MSB`/`LSB`, `CNT_MSB`/`LSB`);
  - `WORD_BYTES` = 4.
- Sub-module `rle_word_packer` is a 32-bit accumulator with lane width 8 or 16 selected by mode. It provides push, flush, full flag, zero-fill and byte count. It is reused by both directions.

## Test plan
- Compress, `src_size` = 8, bytes AA AA AA BB CC CC CC CC → dst word 0 = 0xBB01_AA03, word 1 = 0x0000_CC04, `dst_size` = 6.
- Compress, 300 bytes of 0x55, MAX_RUN = 255 → word 0 = 0x552D_55FF, `dst_size` = 4, `done` high.
- Decompress, `src_size` = 6, words 0xBB01_AA03 and 0x0000_CC04 → output AA AA AA BB CC CC CC CC, `dst_size` = 8.
- Decompress with an embedded 0x0000 padding pair → padding skipped; output identical to the previous scenario.
- `src_size` = 0 in either mode → no `we` pulses, `dst_size` = 0, `done` within 3 cycles.
- Assert `nreset` mid-frame, then issue a fresh `start`:
  - During reset, `we` is 0 and `done`/`busy`/`dst_size` are 0.
  - The second frame result matches the golden model.
  - A `start` pulse while `busy` is ignored.
